// File: rtl/next_op_pkg.sv
// Opcode constants, audio control mask, FSM states and grouped status fields
// shared by the op stream decoder, its interface and its sample FIFO.
package next_op_pkg;

  localparam int OP_W = 24;

  localparam logic [7:0] OP_SAMPLE  = 8'hC7;
  localparam logic [7:0] OP_ATT     = 8'hC4;
  localparam logic [7:0] OP_KBD     = 8'hC5;
  localparam logic [7:0] OP_MIC_ON  = 8'h0B;
  localparam logic [7:0] OP_MIC_OFF = 8'h03;
  localparam logic [7:0] OP_ALL1    = 8'hFF;

  localparam logic [7:0] KBD_PWR_ON = 8'hEF;
  localparam logic [7:0] KBD_LED    = 8'h00;

  // Audio control ops look like 8'b00??x111.
  localparam logic [7:0] AUD_CTRL_MASK  = 8'hC7;
  localparam logic [7:0] AUD_CTRL_MATCH = 8'h07;

  typedef enum logic [1:0] {IDLE, PRIME, PLAY, DRAIN} aud_state_e;

  typedef struct packed {
    logic       mic_active;
    logic       audio_22khz;
    logic       zero_fill;
    logic [7:0] att_data;
    logic [7:0] kbd_led;
  } cfg_t;

  typedef struct packed {
    logic att_update;
    logic kbd_led_update;
    logic power_on_r1;
    logic link_reset;
    logic underrun;
    logic sample_valid;
  } strb_t;

  function automatic logic is_aud_ctrl(input logic [7:0] cmd);
    return (cmd & AUD_CTRL_MASK) == AUD_CTRL_MATCH;
  endfunction

endpackage

// File: rtl/op_stream_decoder_if.sv
// Host op stream: 24-bit op with valid/ready, accepted when both are high.
// The decoder drives op_ready from a register, never from op_valid.
interface op_stream_decoder_if;
  import next_op_pkg::*;

  logic [OP_W-1:0] op_in;
  logic            op_valid;
  logic            op_ready;

  modport master (output op_in, output op_valid, input op_ready);
  modport slave  (input op_in, input op_valid, output op_ready);
endinterface

// File: rtl/sample_fifo.sv
// Sample-word sync FIFO: single-word push, NUM_CH-word pop, flush; registered state.
// Pop data is combinational from the read pointer; a push is refused when full.
module sample_fifo #(
  parameter int SAMPLE_W   = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          push_vld,
  input  logic [SAMPLE_W-1:0]           push_dat,
  input  logic                          pop_vld,
  input  logic                          flush,
  output logic [NUM_CH*SAMPLE_W-1:0]    pop_dat,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          full,
  output logic                          full_nxt
);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int LW = PW + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(FIFO_DEPTH);
  localparam logic [LW-1:0] POP_L   = LW'(NUM_CH);

  logic [SAMPLE_W-1:0] mem_q [FIFO_DEPTH];
  logic [SAMPLE_W-1:0] mem_d [FIFO_DEPTH];
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]       count_q, count_d;
  logic                push_ok;

  assign full     = (count_q == DEPTH_L);
  assign full_nxt = (count_d == DEPTH_L);
  assign push_ok  = push_vld && !full;
  assign level    = count_q;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    // A flush keeps a word pushed in the same cycle.
    if (flush) begin
      rd_ptr_d = wr_ptr_q;
      count_d  = push_ok ? LW'(1) : '0;
    end else begin
      if (pop_vld) begin
        rd_ptr_d = rd_ptr_q + PW'(NUM_CH);
        count_d  = count_d - POP_L;
      end
      if (push_ok) count_d = count_d + LW'(1);
    end
  end

  always_comb begin
    pop_dat = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      pop_dat[c*SAMPLE_W +: SAMPLE_W] = mem_q[rd_ptr_q + PW'(c)];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end
endmodule

// File: rtl/op_stream_decoder.sv
// Decodes host ops into registered strobes/status and plays buffered samples on sample_tick.
// All outputs 1 cycle after acceptance or tick; op_ready is registered !fifo_full.
module op_stream_decoder
  import next_op_pkg::*;
#(
  parameter int SAMPLE_W   = 16,
  parameter int NUM_CH     = 2,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        reset_n,
  op_stream_decoder_if.slave          op_if,
  input  logic                        sample_tick,
  output logic [NUM_CH*SAMPLE_W-1:0]  sample_out,
  output logic                        sample_valid,
  output logic                        audio_active,
  output logic                        audio_22khz,
  output logic                        zero_fill,
  output logic                        underrun,
  output logic [7:0]                  att_data,
  output logic                        att_update,
  output logic [7:0]                  kbd_led,
  output logic                        kbd_led_update,
  output logic                        power_on_r1,
  output logic                        link_reset,
  output logic                        mic_active,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  aud_state_e                 state_q, state_d;
  cfg_t                       cfg_q, cfg_d;
  strb_t                      strb_q, strb_d;
  logic [NUM_CH*SAMPLE_W-1:0] sample_out_q, sample_out_d, pop_dat;
  logic                       phase_q, phase_d;
  logic                       op_ready_q;
  logic [7:0]                 cmd, d1, d2;
  logic                       acc, all1, ctrl_vld, tick_act, pop_slot, have_frame;
  logic                       push_vld, pop_vld, flush, fifo_full, fifo_full_nxt;

  assign cmd        = op_if.op_in[23:16];
  assign d1         = op_if.op_in[15:8];
  assign d2         = op_if.op_in[7:0];
  assign acc        = op_if.op_valid && op_ready_q;
  assign all1       = acc && (cmd == OP_ALL1);
  assign ctrl_vld   = acc && is_aud_ctrl(cmd);
  assign tick_act   = sample_tick && audio_active && !all1;
  assign pop_slot   = !cfg_q.audio_22khz || !phase_q;
  assign have_frame = (fifo_level >= LW'(NUM_CH));

  always_comb begin
    cfg_d        = cfg_q;
    strb_d       = '0;
    state_d      = state_q;
    phase_d      = phase_q;
    sample_out_d = sample_out_q;
    push_vld     = 1'b0;
    pop_vld      = 1'b0;
    flush        = 1'b0;

    if (acc) begin
      if (cmd == OP_KBD) begin
        if (d1 == KBD_PWR_ON) begin
          strb_d.power_on_r1 = 1'b1;
        end else if (d1 == KBD_LED) begin
          cfg_d.kbd_led         = d2;
          strb_d.kbd_led_update = 1'b1;
        end
      end else if (cmd == OP_ATT) begin
        if (d2 == 8'h00) begin
          cfg_d.att_data    = d1;
          strb_d.att_update = 1'b1;
        end
      end else if (cmd == OP_SAMPLE) begin
        push_vld = 1'b1;
      end else if (cmd == OP_MIC_ON) begin
        cfg_d.mic_active = 1'b1;
      end else if (cmd == OP_MIC_OFF) begin
        cfg_d.mic_active = 1'b0;
      end else if (cmd == OP_ALL1) begin
        strb_d.link_reset = 1'b1;
        flush             = 1'b1;
        cfg_d.mic_active  = 1'b0;
        cfg_d.att_data    = 8'h00;
      end else if (is_aud_ctrl(cmd)) begin
        cfg_d.audio_22khz = cmd[4];
        cfg_d.zero_fill   = cmd[5];
      end
    end

    // Ticks use the mode bits latched before this cycle's op.
    if (tick_act) begin
      strb_d.sample_valid = 1'b1;
      phase_d             = cfg_q.audio_22khz ? !phase_q : 1'b0;
      if (pop_slot) begin
        if (have_frame) begin
          pop_vld      = 1'b1;
          sample_out_d = pop_dat;
        end else begin
          sample_out_d    = '0;
          flush           = 1'b1;
          strb_d.underrun = !(state_q == DRAIN && fifo_level == '0);
        end
      end else if (cfg_q.zero_fill) begin
        sample_out_d = '0;
      end
    end

    case (state_q)
      IDLE:  if (ctrl_vld && cmd[3]) state_d = PRIME;
      PRIME: begin
        if (ctrl_vld && !cmd[3]) begin
          state_d = IDLE;
        end else if (have_frame) begin
          state_d = PLAY;
          phase_d = 1'b0;
        end
      end
      PLAY:  if (ctrl_vld && !cmd[3]) state_d = DRAIN;
      DRAIN: if (tick_act && pop_slot && fifo_level == '0) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (all1) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      cfg_q        <= '0;
      strb_q       <= '0;
      phase_q      <= 1'b0;
      sample_out_q <= '0;
      op_ready_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      cfg_q        <= cfg_d;
      strb_q       <= strb_d;
      phase_q      <= phase_d;
      sample_out_q <= sample_out_d;
      op_ready_q   <= !fifo_full_nxt;
    end
  end

  sample_fifo #(
    .SAMPLE_W   (SAMPLE_W),
    .NUM_CH     (NUM_CH),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset_n  (reset_n),
    .push_vld (push_vld),
    .push_dat (op_if.op_in[SAMPLE_W-1:0]),
    .pop_vld  (pop_vld),
    .flush    (flush),
    .pop_dat  (pop_dat),
    .level    (fifo_level),
    .full     (fifo_full),
    .full_nxt (fifo_full_nxt)
  );

  assign op_if.op_ready = op_ready_q;
  assign audio_active   = (state_q == PLAY) || (state_q == DRAIN);
  assign sample_out     = sample_out_q;
  assign sample_valid   = strb_q.sample_valid;
  assign underrun       = strb_q.underrun;
  assign att_update     = strb_q.att_update;
  assign kbd_led_update = strb_q.kbd_led_update;
  assign power_on_r1    = strb_q.power_on_r1;
  assign link_reset     = strb_q.link_reset;
  assign audio_22khz    = cfg_q.audio_22khz;
  assign zero_fill      = cfg_q.zero_fill;
  assign att_data       = cfg_q.att_data;
  assign kbd_led        = cfg_q.kbd_led;
  assign mic_active     = cfg_q.mic_active;
endmodule

// File: tb/tb_op_stream_decoder.sv
// Directed vector tables and hand sequences, then random traffic against a queue-based model.
module tb_op_stream_decoder;
  localparam int SAMPLE_W = 16;
  localparam int NUM_CH = 2;
  localparam int DEPTH = 8;
  localparam int OUT_W = NUM_CH * SAMPLE_W;
  localparam int S_IDLE = 0, S_PRIME = 1, S_PLAY = 2, S_DRAIN = 3;

  logic clk = 1'b0;
  logic reset_n, sample_tick;
  logic [OUT_W-1:0] sample_out;
  logic sample_valid, audio_active, audio_22khz, zero_fill, underrun;
  logic [7:0] att_data, kbd_led;
  logic att_update, kbd_led_update, power_on_r1, link_reset, mic_active;
  logic [$clog2(DEPTH):0] fifo_level;

  op_stream_decoder_if bus();

  op_stream_decoder #(.SAMPLE_W(SAMPLE_W), .NUM_CH(NUM_CH), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .reset_n(reset_n), .op_if(bus), .sample_tick(sample_tick),
    .sample_out(sample_out), .sample_valid(sample_valid), .audio_active(audio_active),
    .audio_22khz(audio_22khz), .zero_fill(zero_fill), .underrun(underrun),
    .att_data(att_data), .att_update(att_update), .kbd_led(kbd_led),
    .kbd_led_update(kbd_led_update), .power_on_r1(power_on_r1), .link_reset(link_reset),
    .mic_active(mic_active), .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic v; logic [23:0] op; logic tk;
    logic sv; logic [OUT_W-1:0] out; logic und;
  } vec_t;
  vec_t tbl[$];

  // Reference model state
  logic [SAMPLE_W-1:0] m_q[$];
  int m_st;
  logic m_ready, m_sv, m_und, m_attu, m_kbdu, m_pwr, m_lr, m_mic, m_22, m_zf, m_phase;
  logic [7:0] m_att, m_kbd;
  logic [OUT_W-1:0] m_out;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic model_step(input logic rn, input logic v, input logic [23:0] op, input logic tk);
    logic [7:0] cmd, d1, d2;
    logic acc, all1, ctrl, start, active, slot;
    int lvl, nst;
    if (!rn) begin
      m_q.delete(); m_st = S_IDLE; m_ready = 0; m_out = '0;
      m_sv = 0; m_und = 0; m_attu = 0; m_kbdu = 0; m_pwr = 0; m_lr = 0;
      m_mic = 0; m_22 = 0; m_zf = 0; m_phase = 0; m_att = 0; m_kbd = 0;
      return;
    end
    cmd = op[23:16]; d1 = op[15:8]; d2 = op[7:0];
    acc = v && m_ready;
    lvl = m_q.size();
    m_sv = 0; m_und = 0; m_attu = 0; m_kbdu = 0; m_pwr = 0; m_lr = 0;
    all1 = acc && cmd == 8'hFF;
    ctrl = acc && cmd[7:6] == 2'b00 && cmd[2:0] == 3'b111;
    start = cmd[3];
    active = (m_st == S_PLAY) || (m_st == S_DRAIN);
    nst = m_st;
    case (m_st)
      S_IDLE:  if (ctrl && start) nst = S_PRIME;
      S_PRIME: if (ctrl && !start) nst = S_IDLE; else if (lvl >= NUM_CH) nst = S_PLAY;
      S_PLAY:  if (ctrl && !start) nst = S_DRAIN;
      default: ;
    endcase
    if (tk && active && !all1) begin
      m_sv = 1;
      slot = !m_22 || !m_phase;
      if (slot) begin
        if (lvl >= NUM_CH) begin
          for (int c = 0; c < NUM_CH; c++) m_out[c*SAMPLE_W +: SAMPLE_W] = m_q.pop_front();
        end else begin
          m_out = '0;
          if (m_st == S_DRAIN && lvl == 0) nst = S_IDLE; else m_und = 1;
          m_q.delete();
        end
      end else if (m_zf) begin
        m_out = '0;
      end
      m_phase = m_22 ? !m_phase : 1'b0;
    end
    if (all1) nst = S_IDLE;
    if (m_st == S_PRIME && nst == S_PLAY) m_phase = 0;
    if (acc) begin
      if (cmd == 8'hC5) begin
        if (d1 == 8'hEF) m_pwr = 1;
        else if (d1 == 8'h00) begin m_kbd = d2; m_kbdu = 1; end
      end else if (cmd == 8'hC4) begin
        if (d2 == 0) begin m_att = d1; m_attu = 1; end
      end else if (cmd == 8'hC7) m_q.push_back(op[SAMPLE_W-1:0]);
      else if (cmd == 8'h0B) m_mic = 1;
      else if (cmd == 8'h03) m_mic = 0;
      else if (cmd == 8'hFF) begin m_q.delete(); m_lr = 1; m_mic = 0; m_att = 0; end
      else if (ctrl) begin m_22 = cmd[4]; m_zf = cmd[5]; end
    end
    m_st = nst;
    m_ready = (m_q.size() != DEPTH);
  endtask

  task automatic step(input logic rn, input logic v, input logic [23:0] op, input logic tk);
    reset_n = rn; bus.op_valid = v; bus.op_in = op; sample_tick = tk;
    @(posedge clk);
    model_step(rn, v, op, tk);
    #1;
  endtask

  task automatic check_model(input int cyc);
    string s;
    s = $sformatf("rnd%0d", cyc);
    chk({s, "_out"}, sample_out, m_out);
    chk({s, "_sv"}, sample_valid, m_sv);
    chk({s, "_active"}, audio_active, (m_st == S_PLAY || m_st == S_DRAIN));
    chk({s, "_22k"}, audio_22khz, m_22);
    chk({s, "_zf"}, zero_fill, m_zf);
    chk({s, "_und"}, underrun, m_und);
    chk({s, "_att"}, att_data, m_att);
    chk({s, "_attu"}, att_update, m_attu);
    chk({s, "_kbd"}, kbd_led, m_kbd);
    chk({s, "_kbdu"}, kbd_led_update, m_kbdu);
    chk({s, "_pwr"}, power_on_r1, m_pwr);
    chk({s, "_lr"}, link_reset, m_lr);
    chk({s, "_mic"}, mic_active, m_mic);
    chk({s, "_lvl"}, fifo_level, m_q.size());
    chk({s, "_rdy"}, bus.op_ready, m_ready);
  endtask

  task automatic add(input logic v, input logic [23:0] op, input logic tk,
                     input logic sv, input logic [OUT_W-1:0] out, input logic und);
    vec_t e;
    e.v = v; e.op = op; e.tk = tk; e.sv = sv; e.out = out; e.und = und;
    tbl.push_back(e);
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl.size(); i++) begin
      step(1, tbl[i].v, tbl[i].op, tbl[i].tk);
      chk($sformatf("%s_row%0d_sv", tag, i), sample_valid, tbl[i].sv);
      chk($sformatf("%s_row%0d_und", tag, i), underrun, tbl[i].und);
      if (tbl[i].sv) chk($sformatf("%s_row%0d_out", tag, i), sample_out, tbl[i].out);
    end
    tbl.delete();
    step(1, 1, 24'hFF0000, 0);
    step(1, 0, 0, 0);
  endtask

  task automatic prime_play(input logic [7:0] ctl, input int n);
    step(1, 1, {ctl, 16'h0}, 0);
    for (int i = 0; i < n; i++) step(1, 1, {8'hC7, 8'(i + 1), 8'(i + 1)}, 0);
  endtask

  initial begin
    logic [23:0] op;
    logic [7:0] c;
    int r;
    reset_n = 0; bus.op_valid = 0; bus.op_in = 0; sample_tick = 0;
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    chk("rst_ready", bus.op_ready, 0);
    chk("rst_level", fifo_level, 0);
    chk("rst_active", audio_active, 0);
    chk("rst_sv", sample_valid, 0);
    chk("rst_out", sample_out, 0);
    chk("rst_mic", mic_active, 0);
    chk("rst_att", att_data, 0);
    step(1, 0, 0, 0);
    chk("rel_ready", bus.op_ready, 1);

    // Attenuation and keyboard ops
    step(1, 1, 24'hC43A00, 0);
    chk("att_data", att_data, 8'h3A); chk("att_upd", att_update, 1);
    step(1, 1, 24'hC45501, 0);
    chk("att_hold", att_data, 8'h3A); chk("att_noupd", att_update, 0);
    step(1, 1, 24'hC500A5, 0);
    chk("kbd_led", kbd_led, 8'hA5); chk("kbd_upd", kbd_led_update, 1);
    step(1, 1, 24'hC5EF00, 0);
    chk("pwr_on", power_on_r1, 1); chk("kbd_hold", kbd_led, 8'hA5); chk("kbd_noupd", kbd_led_update, 0);
    step(1, 0, 0, 0);
    chk("pwr_off", power_on_r1, 0);

    // 44 kHz play with underrun
    add(1, 24'h0F0000, 0, 0, 0, 0);
    add(1, 24'hC71111, 0, 0, 0, 0);
    add(1, 24'hC72222, 0, 0, 0, 0);
    add(1, 24'hC73333, 0, 0, 0, 0);
    add(1, 24'hC74444, 0, 0, 0, 0);
    add(0, 0, 1, 1, 32'h22221111, 0);
    add(0, 0, 1, 1, 32'h44443333, 0);
    add(0, 0, 1, 1, 32'h0, 1);
    add(0, 0, 0, 0, 0, 0);
    run_table("p44");

    // 22 kHz repeat, then zero-fill
    for (int m = 0; m < 2; m++) begin
      add(1, (m == 0) ? 24'h1F0000 : 24'h3F0000, 0, 0, 0, 0);
      add(1, 24'hC7A000, 0, 0, 0, 0);
      add(1, 24'hC7A001, 0, 0, 0, 0);
      add(1, 24'hC7B000, 0, 0, 0, 0);
      add(1, 24'hC7B001, 0, 0, 0, 0);
      add(0, 0, 1, 1, 32'hA001A000, 0);
      add(0, 0, 1, 1, (m == 0) ? 32'hA001A000 : 32'h0, 0);
      add(0, 0, 1, 1, 32'hB001B000, 0);
      add(0, 0, 1, 1, (m == 0) ? 32'hB001B000 : 32'h0, 0);
      run_table((m == 0) ? "p22rep" : "p22zf");
    end

    // Fill to full, refused push, one pop
    prime_play(8'h0F, DEPTH);
    chk("full_ready", bus.op_ready, 0);
    chk("full_level", fifo_level, DEPTH);
    step(1, 1, 24'hC7DEAD, 0);
    chk("full_refused", fifo_level, DEPTH);
    step(1, 0, 0, 1);
    chk("pop_level", fifo_level, DEPTH - NUM_CH);
    step(1, 0, 0, 0);
    chk("pop_ready", bus.op_ready, 1);
    step(1, 1, 24'hFF0000, 0);

    // Drain: 6 words, end op, 4 ticks
    prime_play(8'h0F, 6);
    step(1, 1, 24'h070000, 0);
    for (int t = 0; t < 3; t++) begin
      step(1, 0, 0, 1);
      chk($sformatf("drain_out%0d", t), sample_out, {16'(t*2 + 2) * 16'h0101, 16'(t*2 + 1) * 16'h0101});
      chk($sformatf("drain_und%0d", t), underrun, 0);
      chk($sformatf("drain_act%0d", t), audio_active, 1);
    end
    step(1, 0, 0, 1);
    chk("drain_last_sv", sample_valid, 1);
    chk("drain_last_out", sample_out, 0);
    chk("drain_last_und", underrun, 0);
    chk("drain_idle", audio_active, 0);

    // FF mid-play with mic on
    step(1, 1, 24'hC42200, 0);
    step(1, 1, 24'h0B0000, 0);
    prime_play(8'h0F, 3);
    chk("ff_pre_act", audio_active, 1);
    chk("ff_pre_mic", mic_active, 1);
    step(1, 1, 24'hFF0000, 0);
    chk("ff_lr", link_reset, 1);
    chk("ff_level", fifo_level, 0);
    chk("ff_act", audio_active, 0);
    chk("ff_mic", mic_active, 0);
    chk("ff_att", att_data, 0);
    step(1, 0, 0, 0);
    chk("ff_lr_off", link_reset, 0);

    // Reset mid-play with mic on
    step(1, 1, 24'h0B0000, 0);
    prime_play(8'h0F, 3);
    chk("rst_pre_act", audio_active, 1);
    step(0, 0, 0, 1);
    chk("rstm_level", fifo_level, 0);
    chk("rstm_act", audio_active, 0);
    chk("rstm_mic", mic_active, 0);
    chk("rstm_lr", link_reset, 0);
    chk("rstm_sv", sample_valid, 0);
    step(1, 0, 0, 0);
    chk("rstm_ready", bus.op_ready, 1);

    // Random traffic against the model
    step(0, 0, 0, 0);
    for (int cyc = 0; cyc < 3000; cyc++) begin
      r = $urandom_range(0, 99);
      c = 8'h07;
      if (r < 40) op = {8'hC7, 16'($urandom)};
      else if (r < 52) begin
        c[3] = ($urandom_range(0, 9) < 7);
        c[4] = 1'($urandom_range(0, 1));
        c[5] = 1'($urandom_range(0, 1));
        op = {c, 16'($urandom)};
      end
      else if (r < 58) op = {8'hC4, 8'($urandom), ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom)};
      else if (r < 64) op = {8'hC5, ($urandom_range(0, 2) == 0) ? 8'hEF : (($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom)), 8'($urandom)};
      else if (r < 70) op = {($urandom_range(0, 1) == 0) ? 8'h0B : 8'h03, 16'($urandom)};
      else if (r < 72) op = 24'hFF0000;
      else op = 24'($urandom);
      step(($urandom_range(0, 499) != 0), ($urandom_range(0, 3) != 0), op, ($urandom_range(0, 3) == 0));
      check_model(cyc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
